// File: rtl/triangle_fetcher.sv
// Walks the face list once per frame, fetches the three vertices of each face from
// synchronous ROMs, optionally culls back-facing/degenerate faces and hands the rest to the drawer.
module triangle_fetcher #(
  parameter int unsigned NUM_FACES = 12,
  parameter int unsigned VIDX_W    = 6,
  parameter bit          CULL_EN   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  output logic [9:0]            idx_addr,
  input  logic [3*VIDX_W-1:0]   idx_data,
  output logic [VIDX_W-1:0]     vtx_addr,
  input  logic [1:0][9:0]       vtx_data,
  output logic [1:0][9:0]       V1,
  output logic [1:0][9:0]       V2,
  output logic [1:0][9:0]       V3,
  output logic                  tri_start,
  input  logic                  tri_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic [9:0]            faces_drawn,
  output logic [9:0]            faces_culled
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] LAST_FACE = CW'(NUM_FACES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_IDX, S_LATCH_IDX, S_FETCH_V1, S_FETCH_V2, S_FETCH_V3, S_LATCH_V3,
    S_CULL, S_START, S_WAIT_DONE, S_RELEASE, S_NEXT, S_FDONE
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       face;
  logic [VIDX_W-1:0]   i2, i3;

  logic signed [10:0]  dx21, dy21, dx31, dy31;
  logic signed [21:0]  p_a, p_b;
  logic signed [22:0]  area_c;
  logic                cull_c;

  // Signed area of the fetched triangle; coordinates are unsigned, so zero-extend before subtracting
  assign dx21   = $signed({1'b0, V2[0]}) - $signed({1'b0, V1[0]});
  assign dy21   = $signed({1'b0, V2[1]}) - $signed({1'b0, V1[1]});
  assign dx31   = $signed({1'b0, V3[0]}) - $signed({1'b0, V1[0]});
  assign dy31   = $signed({1'b0, V3[1]}) - $signed({1'b0, V1[1]});
  assign p_a    = 22'(dx21) * 22'(dy31);
  assign p_b    = 22'(dy21) * 22'(dx31);
  assign area_c = 23'(p_a) - 23'(p_b);
  assign cull_c = CULL_EN && (area_c[22] || (area_c == '0));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (frame_start) state_nx = S_FETCH_IDX;
      S_FETCH_IDX: state_nx = S_LATCH_IDX;
      S_LATCH_IDX: state_nx = S_FETCH_V1;
      S_FETCH_V1:  state_nx = S_FETCH_V2;
      S_FETCH_V2:  state_nx = S_FETCH_V3;
      S_FETCH_V3:  state_nx = S_LATCH_V3;
      S_LATCH_V3:  state_nx = S_CULL;
      S_CULL:      state_nx = cull_c ? S_NEXT : S_START;
      S_START:     state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (tri_done) state_nx = S_RELEASE;
      // Drawer keeps done high while start is high; wait for it to let go
      S_RELEASE:   if (!tri_done) state_nx = S_NEXT;
      S_NEXT:      state_nx = (face == LAST_FACE) ? S_FDONE : S_FETCH_IDX;
      S_FDONE:     state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Addresses are loaded on entry to their fetch state so the synchronous ROMs answer one cycle later
  always_ff @(posedge Clk) begin
    if (Reset) begin
      face         <= '0;
      idx_addr     <= '0;
      vtx_addr     <= '0;
      i2           <= '0;
      i3           <= '0;
      V1           <= '0;
      V2           <= '0;
      V3           <= '0;
      tri_start    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      faces_drawn  <= '0;
      faces_culled <= '0;
    end else begin
      busy       <= (state_nx != S_IDLE);
      frame_done <= (state_nx == S_FDONE);
      tri_start  <= (state_nx == S_START) || (state_nx == S_WAIT_DONE);
      case (state)
        S_IDLE: if (frame_start) begin
          face         <= '0;
          idx_addr     <= '0;
          faces_drawn  <= '0;
          faces_culled <= '0;
        end
        S_LATCH_IDX: begin
          vtx_addr <= idx_data[VIDX_W-1:0];
          i2       <= idx_data[VIDX_W +: VIDX_W];
          i3       <= idx_data[2*VIDX_W +: VIDX_W];
        end
        S_FETCH_V1: vtx_addr <= i2;
        S_FETCH_V2: begin
          vtx_addr <= i3;
          V1       <= vtx_data;
        end
        S_FETCH_V3: V2 <= vtx_data;
        S_LATCH_V3: V3 <= vtx_data;
        S_CULL:      if (cull_c) faces_culled <= faces_culled + 1'b1;
        S_WAIT_DONE: if (tri_done) faces_drawn <= faces_drawn + 1'b1;
        S_NEXT: if (face != LAST_FACE) begin
          face     <= face + 1'b1;
          idx_addr <= face + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/triangle_fetcher.md
Name: triangle_fetcher

Overview:
- Upstream feeder for the triangle edge renderer. Walks a face list once per frame.
- Each face entry holds three vertex indices into an index ROM. The block looks up the screen-space x,y of each vertex in a vertex ROM.
- Optionally culls back-facing and degenerate triangles.
- Runs the start/done handshake with the triangle drawer once per surviving face, then signals frame completion.

Parameters:
- NUM_FACES, 12, number of faces per frame; legal range 1..1023.
- VIDX_W, 6, width of one vertex index; vertex ROM depth is 2^VIDX_W.
- CULL_EN, 1, 1 = skip faces with signed area <= 0; 0 = draw every face.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- frame_start  in  1  level; a high sample while in IDLE starts one pass
- idx_addr  out  10  face index into index ROM
- idx_data  in  3*VIDX_W  {i3,i2,i1}, i1 in LSBs; valid one cycle after idx_addr
- vtx_addr  out  VIDX_W  vertex ROM address
- vtx_data  in  [1:0][9:0]  [0]=x, [1]=y; valid one cycle after vtx_addr
- V1, V2, V3  out  [1:0][9:0] each  vertices to drawer; [0]=x, [1]=y
- tri_start  out  1  drawer start; held high until drawer done
- tri_done  in  1  drawer done
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of pass
- faces_drawn  out  10  faces handed to drawer in current/last pass
- faces_culled  out  10  faces skipped in current/last pass

Behaviour:
- Reset: state IDLE. Every output is 0: V1..V3, idx_addr, vtx_addr, tri_start, busy, frame_done, both counters. Internal face counter is 0. Reset mid-pass aborts at the next edge; tri_start drops immediately.
- IDLE:
  - if frame_start, clear face counter, faces_drawn and faces_culled -> FETCH_IDX.
  - frame_start is ignored in every other state.
- FETCH_IDX: idx_addr = face -> LATCH_IDX.
- LATCH_IDX: register i1,i2,i3 from idx_data -> FETCH_V1.
- FETCH_V1: vtx_addr = i1 -> FETCH_V2.
- FETCH_V2: vtx_addr = i2; V1 <= vtx_data -> FETCH_V3.
- FETCH_V3: vtx_addr = i3; V2 <= vtx_data -> LATCH_V3.
- LATCH_V3: V3 <= vtx_data -> CULL.
- CULL:
  - A = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1).
  - Differences are signed 11-bit, zero-extended from 10 bits; products are signed 22-bit; A is signed 23-bit, exact with no overflow.
  - If CULL_EN and A <= 0: faces_culled++ -> NEXT.
  - Otherwise -> START.
  - With CULL_EN=0, A is not evaluated and the face always goes to START.
- START: tri_start = 1 -> WAIT_DONE.
- WAIT_DONE:
  - tri_start stays 1.
  - On tri_done = 1: faces_drawn++ -> RELEASE.
- RELEASE:
  - tri_start = 0.
  - Stay until tri_done = 0, because the drawer holds done while start is high. Then -> NEXT.
- NEXT:
  - If face == NUM_FACES-1 -> FDONE.
  - Else face++ -> FETCH_IDX.
- FDONE: frame_done = 1 for exactly this cycle -> IDLE. Counters hold their values until the next frame_start.
- Signal stability:
  - V1..V3 are registered and change only in FETCH_V2/FETCH_V3/LATCH_V3, never while tri_start is high.
  - idx_addr and vtx_addr are registered outputs and hold their last value outside their fetch states.
- Latency:
  - Culled face: 8 cycles, FETCH_IDX through NEXT.
  - Drawn face: 10 cycles + drawer time.
- Simultaneous events:
  - tri_done already high on entry to WAIT_DONE (stale) is still accepted. The drawer guarantees done is low after RELEASE, so this cannot occur in normal operation.
  - frame_start held high through FDONE starts a new pass from the following IDLE cycle. No pass is ever dropped or merged.

Test Plan:
- Reset held 3 cycles during WAIT_DONE -> tri_start=0, busy=0, counters=0, state IDLE. Then frame_start -> fresh pass starting at face 0.
- NUM_FACES=2, CULL_EN=0; face0=(0,1,2), verts (10,10),(100,10),(10,100); drawer model asserts done 5 cycles after start -> V1..V3 match; tri_start high until done; faces_drawn=2; frame_done one pulse.
- CULL_EN=1, vertices (10,10),(10,100),(100,10) (A=-8100) -> no tri_start; faces_culled=1. Swapping V2/V3 (A=+8100) -> drawn.
- Degenerate collinear (0,0),(5,5),(10,10), CULL_EN=1 -> A=0, culled. Extreme (0,0),(1023,0),(0,1023) -> A=1046529, drawn, no overflow.
- Drawer holds done high 4 cycles after start drops -> block stays in RELEASE; next idx fetch occurs only after done low; no double count.
- frame_start pulsed mid-pass -> ignored. frame_start held high continuously -> back-to-back passes, frame_done pulse per pass, counters reset at each pass start.
